// File: rtl/my_pkg.sv
// Shared parameters, FSM state type and request packet builder for the fetch path.
package my_pkg;

    localparam int MESH_SIZE     = 4;
    localparam int COORD_LENGTH  = 2;
    localparam int ADDR_LENGTH   = 8;
    localparam int FEATURES      = 4;
    localparam int DATA_WIDTH    = 8;
    localparam int PACKET_LENGTH = 24;

    // Row index sits in the low bits of a neighbour address.
    localparam int ROW_LENGTH = ADDR_LENGTH - 2 * COORD_LENGTH;
    // Zero fill between the source coordinates and the row field of a request.
    localparam int PAD_LENGTH = PACKET_LENGTH - 1 - 4 * COORD_LENGTH - ROW_LENGTH;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        OUT
    } fsched_state_t;

    // Request flit: {1, dest x, dest y, src x, src y, zero pad, row}.
    function automatic logic [PACKET_LENGTH-1:0] build_req_pkt(
        input logic [ADDR_LENGTH-1:0]  addr,
        input logic [COORD_LENGTH-1:0] x,
        input logic [COORD_LENGTH-1:0] y
    );
        build_req_pkt = {1'b1,
                         addr[ADDR_LENGTH-1 -: 2*COORD_LENGTH],
                         x,
                         y,
                         {PAD_LENGTH{1'b0}},
                         addr[ROW_LENGTH-1:0]};
    endfunction

endpackage

// File: rtl/fetch_scheduler_inj_port_arbiter.sv
// Two-way round-robin mux sharing the local injection port between this
// scheduler's request flit and the co-located response unit's flits.
module inj_port_arbiter
    import my_pkg::*;
(
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     req_vld,
    input  logic [PACKET_LENGTH-1:0] req_pkt,
    input  logic                     resp_vld,
    input  logic [PACKET_LENGTH-1:0] resp_pkt,
    input  logic                     inj_read,
    output logic                     inj_vld,
    output logic [PACKET_LENGTH-1:0] inj_pkt,
    output logic                     resp_stall,
    output logic                     req_grant
);

    // 1 when the request side was served by the most recent transfer.
    logic last_req_q;

    // Grant depends only on registered state and resp_vld, never on inj_read.
    always_comb begin
        req_grant  = req_vld && (!resp_vld || !last_req_q);
        resp_stall = req_grant;
        inj_vld    = req_grant || resp_vld;
        inj_pkt    = req_grant ? req_pkt : resp_pkt;
    end

    // Remember which side moved a flit so the other side wins the next tie.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            last_req_q <= 1'b0;
        end else if (inj_vld && inj_read) begin
            last_req_q <= req_grant;
        end
    end

endmodule

// File: rtl/fetch_scheduler.sv
// Issues one read request per neighbour address, collects the returned
// feature flits and hands the assembled vector to the aggregator.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | ready for the next neighbour address
//  SEND  | request flit presented on the shared injection port
//  WAIT  | collecting FEATURES data flits addressed to this node
//  OUT   | assembled vector held until the aggregator takes it
module fetch_scheduler
    import my_pkg::*;
#(
    parameter logic [COORD_LENGTH-1:0] X_COORD = 1,
    parameter logic [COORD_LENGTH-1:0] Y_COORD = 1
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           nbr_vld,
    input  logic [ADDR_LENGTH-1:0]         nbr_addr,
    input  logic                           nbr_last,
    output logic                           nbr_rdy,
    input  logic                           rx_vld,
    input  logic [PACKET_LENGTH-1:0]       rx_pkt,
    output logic                           rx_accept,
    input  logic                           resp_vld,
    input  logic [PACKET_LENGTH-1:0]       resp_pkt,
    output logic                           resp_stall,
    input  logic                           inj_read,
    output logic                           inj_vld,
    output logic [PACKET_LENGTH-1:0]       inj_pkt,
    output logic                           vec_vld,
    output logic [FEATURES*DATA_WIDTH-1:0] vec_data,
    output logic                           vec_last,
    input  logic                           vec_rdy,
    output logic                           busy,
    output logic                           err_misroute
);

    localparam int CNT_W = $clog2(FEATURES + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FEATURES - 1);

    fsched_state_t                  state_q, state_d;
    logic [ADDR_LENGTH-1:0]         addr_q;
    logic                           last_q;
    logic [CNT_W-1:0]               count_q;
    logic [FEATURES*DATA_WIDTH-1:0] vec_q;
    logic                           err_q;

    logic                     req_vld;
    logic                     req_grant;
    logic [PACKET_LENGTH-1:0] req_pkt;
    logic                     dest_ok;
    logic                     unused_rx;

    // Data flits reuse the request layout: dest coordinates right below the MSB.
    assign dest_ok = (rx_pkt[PACKET_LENGTH-2 -: COORD_LENGTH] == X_COORD) &&
                     (rx_pkt[PACKET_LENGTH-2-COORD_LENGTH -: COORD_LENGTH] == Y_COORD);

    // Source coordinates and padding of returned flits carry nothing we need.
    assign unused_rx = ^rx_pkt[PACKET_LENGTH-2-2*COORD_LENGTH : DATA_WIDTH];

    assign req_vld = (state_q == SEND);
    assign req_pkt = build_req_pkt(addr_q, X_COORD, Y_COORD);

    inj_port_arbiter u_arb (
        .clk        (clk),
        .arst_n     (arst_n),
        .req_vld    (req_vld),
        .req_pkt    (req_pkt),
        .resp_vld   (resp_vld),
        .resp_pkt   (resp_pkt),
        .inj_read   (inj_read),
        .inj_vld    (inj_vld),
        .inj_pkt    (inj_pkt),
        .resp_stall (resp_stall),
        .req_grant  (req_grant)
    );

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_d   = state_q;
        nbr_rdy   = 1'b0;
        rx_accept = 1'b0;
        vec_vld   = 1'b0;
        case (state_q)
            IDLE: begin
                nbr_rdy = 1'b1;
                if (nbr_vld) state_d = SEND;
            end
            SEND: begin
                if (req_grant && inj_read) state_d = WAIT;
            end
            WAIT: begin
                rx_accept = rx_vld && !rx_pkt[PACKET_LENGTH-1];
                if (rx_accept && dest_ok && (count_q == LAST_WORD)) state_d = OUT;
            end
            OUT: begin
                vec_vld = 1'b1;
                if (vec_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign vec_data     = vec_q;
    assign vec_last     = vec_vld && last_q;
    assign err_misroute = err_q;

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Address latch, word counter, vector assembly and misroute flag.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            addr_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            vec_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if ((state_q == IDLE) && nbr_vld) begin
                addr_q  <= nbr_addr;
                last_q  <= nbr_last;
                count_q <= '0;
                vec_q   <= '0;
            end
            if (rx_accept) begin
                if (dest_ok) begin
                    vec_q[int'(count_q)*DATA_WIDTH +: DATA_WIDTH] <= rx_pkt[DATA_WIDTH-1:0];
                    count_q <= count_q + 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_scheduler.sv
// Scoreboard bench for fetch_scheduler: expected requests and vectors are
// queued as stimulus is driven and popped when the DUT presents them.
module tb_fetch_scheduler;
    import my_pkg::*;

    logic                           clk = 1'b0;
    logic                           arst_n;
    logic                           nbr_vld;
    logic [ADDR_LENGTH-1:0]         nbr_addr;
    logic                           nbr_last;
    logic                           nbr_rdy;
    logic                           rx_vld;
    logic [PACKET_LENGTH-1:0]       rx_pkt;
    logic                           rx_accept;
    logic                           resp_vld;
    logic [PACKET_LENGTH-1:0]       resp_pkt;
    logic                           resp_stall;
    logic                           inj_read;
    logic                           inj_vld;
    logic [PACKET_LENGTH-1:0]       inj_pkt;
    logic                           vec_vld;
    logic [FEATURES*DATA_WIDTH-1:0] vec_data;
    logic                           vec_last;
    logic                           vec_rdy;
    logic                           busy;
    logic                           err_misroute;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } vec_exp_t;

    logic [23:0] rq[$];
    vec_exp_t    vq[$];
    int          checks   = 0;
    int          failures = 0;

    fetch_scheduler #(.X_COORD(2'd1), .Y_COORD(2'd1)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .nbr_vld      (nbr_vld),
        .nbr_addr     (nbr_addr),
        .nbr_last     (nbr_last),
        .nbr_rdy      (nbr_rdy),
        .rx_vld       (rx_vld),
        .rx_pkt       (rx_pkt),
        .rx_accept    (rx_accept),
        .resp_vld     (resp_vld),
        .resp_pkt     (resp_pkt),
        .resp_stall   (resp_stall),
        .inj_read     (inj_read),
        .inj_vld      (inj_vld),
        .inj_pkt      (inj_pkt),
        .vec_vld      (vec_vld),
        .vec_data     (vec_data),
        .vec_last     (vec_last),
        .vec_rdy      (vec_rdy),
        .busy         (busy),
        .err_misroute (err_misroute)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] make_req(input logic [1:0] x, input logic [1:0] y,
                                             input logic [3:0] row);
        logic [23:0] p;
        p        = '0;
        p[23]    = 1'b1;
        p[22:21] = x;
        p[20:19] = y;
        p[18:17] = 2'd1;
        p[16:15] = 2'd1;
        p[3:0]   = row;
        return p;
    endfunction

    function automatic logic [23:0] make_flit(input logic msb, input logic [1:0] dx,
                                              input logic [1:0] dy, input logic [7:0] d);
        logic [23:0] p;
        p        = '0;
        p[23]    = msb;
        p[22:21] = dx;
        p[20:19] = dy;
        p[7:0]   = d;
        return p;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_nbr_rdy"}, nbr_rdy, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_inj_vld"}, inj_vld, 0);
        chk({tag, "_resp_stall"}, resp_stall, 0);
        chk({tag, "_rx_accept"}, rx_accept, 0);
        chk({tag, "_vec_vld"}, vec_vld, 0);
        chk({tag, "_vec_last"}, vec_last, 0);
        chk({tag, "_err"}, err_misroute, 0);
        chk({tag, "_vec_data"}, vec_data, 0);
        chk({tag, "_inj_pkt"}, inj_pkt, 0);
    endtask

    // Tasks below start and end just after a rising edge.
    task automatic send_addr(input logic [1:0] x, input logic [1:0] y,
                             input logic [3:0] row, input logic last);
        nbr_vld  = 1'b1;
        nbr_addr = {x, y, row};
        nbr_last = last;
        rq.push_back(make_req(x, y, row));
        @(negedge clk);
        chk("addr_rdy", nbr_rdy, 1);
        @(posedge clk); #1;
        nbr_vld = 1'b0;
    endtask

    task automatic feed_flit(input logic [23:0] p, input logic exp_acc);
        rx_vld = 1'b1;
        rx_pkt = p;
        @(negedge clk);
        chk("rx_accept", rx_accept, exp_acc);
        @(posedge clk); #1;
        rx_vld = 1'b0;
        rx_pkt = '0;
    endtask

    task automatic feed_vector(input logic [7:0] base, input logic last);
        vec_exp_t e;
        e.data = '0;
        for (int i = 0; i < 4; i++) e.data[i*8 +: 8] = base * 8'(i + 1);
        e.last = last;
        vq.push_back(e);
        for (int i = 0; i < 4; i++) feed_flit(make_flit(1'b0, 2'd1, 2'd1, base * 8'(i + 1)), 1'b1);
    endtask

    task automatic check_req_on_port(input string tag);
        logic [23:0] e;
        chk({tag, "_sb_depth"}, rq.size(), 1);
        e = rq.pop_front();
        chk({tag, "_inj_pkt"}, inj_pkt, e);
        chk({tag, "_inj_vld"}, inj_vld, 1);
        chk({tag, "_resp_stall"}, resp_stall, 1);
        chk({tag, "_nbr_rdy"}, nbr_rdy, 0);
    endtask

    task automatic finish_vec(input int hold);
        vec_exp_t e;
        @(negedge clk);
        chk("vec_latency", vec_vld, 1);
        chk("vec_sb_depth", vq.size(), 1);
        e = vq.pop_front();
        chk("vec_data", vec_data, e.data);
        chk("vec_last", vec_last, e.last);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("vec_hold_data", vec_data, e.data);
            chk("vec_hold_vld", vec_vld, 1);
        end
        @(posedge clk); #1;
        vec_rdy = 1'b1;
        @(posedge clk); #1;
        vec_rdy = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_nbr_rdy", nbr_rdy, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        arst_n   = 1'b0;
        nbr_vld  = 1'b0;
        nbr_addr = '0;
        nbr_last = 1'b0;
        rx_vld   = 1'b0;
        rx_pkt   = '0;
        resp_vld = 1'b0;
        resp_pkt = '0;
        inj_read = 1'b0;
        vec_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        arst_n = 1'b1;
        @(posedge clk); #1;

        // Contention: response side always valid, request must win first.
        resp_pkt = 24'h0A5A5A;
        resp_vld = 1'b1;
        inj_read = 1'b1;
        send_addr(2'd2, 2'd3, 4'd5, 1'b0);
        @(negedge clk);
        check_req_on_port("cont");
        @(posedge clk); #1;
        @(negedge clk);
        chk("cont_pass_stall", resp_stall, 0);
        chk("cont_pass_pkt", inj_pkt, 24'h0A5A5A);
        chk("cont_pass_vld", inj_vld, 1);
        @(posedge clk); #1;
        resp_vld = 1'b0;
        resp_pkt = '0;
        feed_vector(8'h11, 1'b0);
        finish_vec(0);

        // Injection backpressure, then filtering, then output backpressure.
        inj_read = 1'b0;
        send_addr(2'd3, 2'd0, 4'd9, 1'b1);
        rx_vld = 1'b1;
        rx_pkt = make_flit(1'b0, 2'd1, 2'd1, 8'hEE);
        begin
            logic [23:0] e;
            e = rq.pop_front();
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("bp_inj_pkt", inj_pkt, e);
                chk("bp_inj_vld", inj_vld, 1);
                chk("bp_rx_accept", rx_accept, 0);
                chk("bp_nbr_rdy", nbr_rdy, 0);
                @(posedge clk); #1;
            end
        end
        rx_vld = 1'b0;
        rx_pkt = '0;
        inj_read = 1'b1;
        @(posedge clk); #1;
        feed_flit(make_flit(1'b1, 2'd1, 2'd1, 8'h77), 1'b0);
        chk("no_err_on_req", err_misroute, 0);
        feed_flit(make_flit(1'b0, 2'd0, 2'd2, 8'h99), 1'b1);
        @(negedge clk);
        chk("misroute_err", err_misroute, 1);
        chk("misroute_busy", busy, 1);
        @(posedge clk); #1;
        feed_vector(8'h11, 1'b1);
        finish_vec(3);

        // Reset in the middle of collection.
        send_addr(2'd1, 2'd2, 4'd3, 1'b0);
        @(negedge clk);
        check_req_on_port("rst_req");
        @(posedge clk); #1;
        feed_flit(make_flit(1'b0, 2'd1, 2'd1, 8'h01), 1'b1);
        feed_flit(make_flit(1'b0, 2'd1, 2'd1, 8'h02), 1'b1);
        #2 arst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;
        send_addr(2'd1, 2'd2, 4'd3, 1'b0);
        @(negedge clk);
        check_req_on_port("post_rst");
        @(posedge clk); #1;
        feed_vector(8'hA1, 1'b0);
        finish_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run ends even if the DUT wedges somewhere.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_scheduler.md
# fetch_scheduler

Sequences remote feature fetches for one mesh node. It takes neighbour addresses from the aggregation control path and issues one single-flit read-request packet per neighbour into the router's local injection port. It then collects the FEATURES data flits returned by the remote node's response unit and presents the reassembled feature vector to the aggregator. It also owns the local injection port, which it time-shares with the co-located fetch_response_unit through that unit's `stall` input.

## Interface
- X_COORD, 1, this node's mesh X coordinate.
- Y_COORD, 1, this node's mesh Y coordinate.
- clk  in  1  clock; all state changes on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- nbr_vld  in  1  neighbour address valid.
- nbr_addr  in  ADDR_LENGTH  {x, y, local row}; x in top COORD_LENGTH bits, then y, then row in low ADDR_LENGTH-2*COORD_LENGTH bits.
- nbr_last  in  1  last neighbour of the current node list.
- nbr_rdy  out  1  address accepted when nbr_vld && nbr_rdy.
- rx_vld  in  1  router ejection flit valid.
- rx_pkt  in  PACKET_LENGTH  router ejection flit.
- rx_accept  out  1  flit consumed; top level ORs it with the response unit's `reading`.
- resp_vld  in  1  response unit `vld_out`.
- resp_pkt  in  PACKET_LENGTH  response unit `to_router`.
- resp_stall  out  1  drives response unit `stall`.
- inj_read  in  1  router accepts the injected flit this cycle.
- inj_vld  out  1  injected flit valid.
- inj_pkt  out  PACKET_LENGTH  injected flit.
- vec_vld  out  1  assembled vector valid.
- vec_data  out  FEATURES*DATA_WIDTH  assembled vector.
- vec_last  out  1  vector belongs to the nbr_last request.
- vec_rdy  in  1  aggregator accepts the vector.
- busy  out  1  state != IDLE.
- err_misroute  out  1  sticky flag; cleared only by reset.

## Operation
- FSM states: IDLE, SEND, WAIT, OUT. At most one request is outstanding.
- IDLE: nbr_rdy=1. On nbr_vld, latch nbr_addr and nbr_last, clear the word counter, and go to SEND.
- Request packet: {1'b1, addr.x, addr.y, X_COORD[COORD_LENGTH], Y_COORD[COORD_LENGTH], zero pad, addr.row}. The row occupies bits ADDR_LENGTH-2*COORD_LENGTH-1:0.
- SEND: the request is held stable until it is granted and inj_read=1, then the FSM goes to WAIT.
- Injection arbitration is round-robin per transferred flit between the request and response flits. The grant pointer toggles only on a transfer (inj_vld && inj_read).
  - Request granted: inj_pkt = request packet, inj_vld=1, resp_stall=1.
  - Otherwise: inj_pkt = resp_pkt, inj_vld = resp_vld, resp_stall=0.
  - Request and resp_vld contend: the side not served last wins. After reset, the response side is treated as last served, so the request wins the first contention.
- Data flit: rx_pkt MSB = 0.
- WAIT: rx_accept = rx_vld && !rx_pkt[MSB]. Requests (MSB=1) are never accepted here.
  - Flit k (k = 0..FEATURES-1, arrival order) low DATA_WIDTH bits go to vec_data[k*DATA_WIDTH +: DATA_WIDTH].
  - If the flit's destination coordinates do not equal (X_COORD, Y_COORD), the flit is accepted and dropped, the counter does not advance, and err_misroute is set.
  - When flit FEATURES-1 is accepted, the FSM goes to OUT.
- OUT: vec_vld=1, with vec_data and vec_last stable. On vec_rdy, go to IDLE.
- rx_accept=0 in IDLE, SEND and OUT.
- Word counter: width $clog2(FEATURES+1). It does not wrap, because it is cleared on entry to SEND.

## Timing
- Reset values:
  - FSM in IDLE.
  - nbr_rdy=1.
  - busy, inj_vld, resp_stall, rx_accept, vec_vld, vec_last and err_misroute are 0.
  - vec_data, inj_pkt and the counter are 0.
- Address accept to first request presentation: 1 cycle (registered FSM).
- Request with no contention: inj_vld is asserted in the first SEND cycle.
- Last data flit accept to vec_vld: 1 cycle.
- Back-to-back operation: vec_rdy in OUT, then IDLE for 1 cycle, then the next address is accepted. Throughput is 1 request per (FEATURES + network round trip + 3) cycles.
- resp_stall, inj_pkt and inj_vld are combinational from the registered state and the grant pointer plus resp_vld. There is no path from inj_read to resp_stall.
- rx_vld and vec_rdy may be held indefinitely; the FSM waits with no timeout.
- When nbr_vld arrives while a request is in progress, nbr_rdy stays 0 and the address is not lost.
- An asynchronous reset in any state returns the FSM to IDLE immediately. A partial vector is discarded and the outstanding response flits are not drained, so the top level must reset the mesh together with this block.

## Structure
- my_pkg provides PACKET_LENGTH, ADDR_LENGTH, COORD_LENGTH, FEATURES, DATA_WIDTH and MESH_SIZE.
- Add to my_pkg:
  - enum fsched_state_t {IDLE, SEND, WAIT, OUT}
  - a function build_req_pkt(addr, x, y) returning the request packet.
- Sub-module inj_port_arbiter: 2-way round-robin mux with grant pointer, producing inj_pkt, inj_vld and resp_stall.

## Test plan
Bench parameters: FEATURES=4, DATA_WIDTH=8, X_COORD=1, Y_COORD=1, resp_vld=0 unless stated.
- Single fetch:
  - Stimulus: nbr_addr={x=2, y=3, row=5}, inj_read=1.
  - Required: one packet with MSB=1, dest (2,3), src (1,1), row 5.
  - Then feed data flits 0x11, 0x22, 0x33, 0x44 destined (1,1). Required: vec_data=0x44332211 one cycle after the 4th flit, vec_last matches nbr_last.
- Contention:
  - Stimulus: resp_vld=1 continuously while in SEND, inj_read=1.
  - Required: the request is injected in the first SEND cycle with resp_stall=1. The following cycle resp_stall=0 and resp_pkt passes through.
- Backpressure:
  - Stimulus: inj_read=0 for 5 cycles in SEND.
  - Required: request packet stable, rx_accept=0, nbr_rdy=0.
  - Stimulus: vec_rdy=0 for 3 cycles in OUT. Required: vec_data held unchanged.
- Filtering:
  - Stimulus: a request flit (MSB=1) arrives during WAIT. Required: rx_accept=0.
  - Stimulus: a data flit destined (0,2) arrives during WAIT. Required: accepted and dropped, err_misroute=1, counter unchanged.
- Reset mid-WAIT:
  - Stimulus: assert arst_n=0 after 2 flits.
  - Required: immediate return to IDLE with all outputs at their reset values. A new fetch then completes with a clean vector.
